// File: rtl/timer_pkg.sv
// Shared definitions for the timer_counter slice: FSM states, flag bit
// positions and the default counter width.
package timer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  // Bit positions within the two-bit flag vector and flag_clr
  localparam int unsigned FLAG_MATCH = 0;
  localparam int unsigned FLAG_OVF   = 1;
  localparam int unsigned NUM_FLAGS  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tick_sync.sv
// Turns the prescaler's divided clock into a one-cycle count-enable tick in
// the clk domain: two-flop synchroniser, rising-edge detector, bypass mux.
module tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic presc_clk,
  input  logic bypass,
  output logic tick
);

  logic s1;
  logic s2;
  logic prev;

  // Synchroniser and edge-history flops keep sampling even in bypass so that
  // leaving bypass cannot fabricate an extra edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= presc_clk;
      s2   <= s1;
      prev <= s2;
    end
  end

  // One tick per synchronised rising edge, or every cycle when bypassed
  always_comb begin
    tick = 1'b0;
    if (bypass) begin
      tick = 1'b1;
    end else begin
      tick = s2 & ~prev;
    end
  end

endmodule

// File: rtl/timer_counter.sv
// Timer counter: counts prescaler ticks in RUN, raises sticky compare-match
// and overflow flags, supports periodic and one-shot operation.
module timer_counter
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 presc_clk,
  input  logic                 bypass,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 one_shot,
  input  logic [WIDTH-1:0]     period,
  input  logic [WIDTH-1:0]     compare,
  input  logic                 match_ie,
  input  logic                 ovf_ie,
  input  logic [NUM_FLAGS-1:0] flag_clr,
  output logic [WIDTH-1:0]     count,
  output logic                 match_flag,
  output logic                 ovf_flag,
  output logic                 irq,
  output logic                 busy
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q;
  state_t                 state_n;
  logic [WIDTH-1:0]       count_q;
  logic [WIDTH-1:0]       count_n;
  logic [NUM_FLAGS-1:0]   flags_q;
  logic [NUM_FLAGS-1:0]   flags_n;
  logic [NUM_FLAGS-1:0]   flag_set;
  logic                   tick;

  tick_sync u_tick_sync (
    .clk       (clk),
    .rst       (rst),
    .presc_clk (presc_clk),
    .bypass    (bypass),
    .tick      (tick)
  );

  // State, count and flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
      flags_q <= flags_n;
    end
  end

  // Next-state, next-count and flag-set logic. start outranks stop, and both
  // swallow a coincident tick.
  always_comb begin
    state_n  = state_q;
    count_n  = count_q;
    flag_set = '0;
    if (start) begin
      state_n = RUN;
      count_n = '0;
    end else if (stop) begin
      state_n = IDLE;
    end else if (state_q == RUN && tick) begin
      if (count_q == period) begin
        count_n            = '0;
        flag_set[FLAG_OVF] = 1'b1;
        if (one_shot) begin
          state_n = DONE;
        end
      end else begin
        count_n = count_q + ONE;
      end
      if (count_n == compare) begin
        flag_set[FLAG_MATCH] = 1'b1;
      end
    end
  end

  // Sticky flags: a set in the same cycle as its clear wins
  always_comb begin
    flags_n = (flags_q & ~flag_clr) | flag_set;
  end

  // Output decode
  always_comb begin
    count      = count_q;
    match_flag = flags_q[FLAG_MATCH];
    ovf_flag   = flags_q[FLAG_OVF];
    irq        = (flags_q[FLAG_MATCH] & match_ie) | (flags_q[FLAG_OVF] & ovf_ie);
    busy       = (state_q == RUN);
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_timer_counter;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst;
  logic         presc_clk;
  logic         bypass;
  logic         start;
  logic         stop;
  logic         one_shot;
  logic [W-1:0] period;
  logic [W-1:0] compare;
  logic         match_ie;
  logic         ovf_ie;
  logic [1:0]   flag_clr;
  logic [W-1:0] count;
  logic         match_flag;
  logic         ovf_flag;
  logic         irq;
  logic         busy;

  int checks = 0;
  int errors = 0;

  timer_counter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .presc_clk  (presc_clk),
    .bypass     (bypass),
    .start      (start),
    .stop       (stop),
    .one_shot   (one_shot),
    .period     (period),
    .compare    (compare),
    .match_ie   (match_ie),
    .ovf_ie     (ovf_ie),
    .flag_clr   (flag_clr),
    .count      (count),
    .match_flag (match_flag),
    .ovf_flag   (ovf_flag),
    .irq        (irq),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] c, input logic m,
                         input logic o, input logic b);
    chk({tag, ".count"}, 32'(count), c);
    chk({tag, ".match"}, 32'(match_flag), 32'(m));
    chk({tag, ".ovf"}, 32'(ovf_flag), 32'(o));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  // Expected count after each edge of the prescaled run (presc_clk high for
  // edges 4..7, 12..15, 20..23; period=2; 2-cycle latency)
  logic [1:0] presc_exp [24] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1,
                                 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2,
                                 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0};

  initial begin
    rst = 1'b0; presc_clk = 1'b0; bypass = 1'b0; start = 1'b0; stop = 1'b0;
    one_shot = 1'b0; period = '0; compare = '0; match_ie = 1'b0; ovf_ie = 1'b0;
    flag_clr = '0;
    step(); step();
    rst = 1'b1;
    step();

    // Reset state
    chk_all("reset", 0, 1'b0, 1'b0, 1'b0);
    chk("reset.irq", 32'(irq), 0);

    // Bypass periodic count, period=4
    bypass = 1'b1; period = 16'd4; compare = 16'd15; one_shot = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    chk_all("byp.start", 0, 1'b0, 1'b0, 1'b1);
    step(); chk_all("byp.c1", 1, 1'b0, 1'b0, 1'b1);
    step(); chk_all("byp.c2", 2, 1'b0, 1'b0, 1'b1);
    step(); chk_all("byp.c3", 3, 1'b0, 1'b0, 1'b1);
    step(); chk_all("byp.c4", 4, 1'b0, 1'b0, 1'b1);
    step(); chk_all("byp.wrap", 0, 1'b0, 1'b1, 1'b1);
    step(); chk_all("byp.c1b", 1, 1'b0, 1'b1, 1'b1);
    stop = 1'b1; step(); stop = 1'b0;
    chk_all("byp.stop", 1, 1'b0, 1'b1, 1'b0);
    step(); step(); step();
    chk_all("byp.hold", 1, 1'b0, 1'b1, 1'b0);
    flag_clr = 2'b11; step(); flag_clr = '0;
    chk_all("byp.clr", 1, 1'b0, 1'b0, 1'b0);

    // Prescaled count, presc period 8 clk, period=2
    bypass = 1'b0; period = 16'd2; compare = 16'd15; presc_clk = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    chk_all("presc.start", 0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 24; c++) begin
      presc_clk = ((c / 4) % 2) == 1;
      step();
      chk($sformatf("presc.c%0d", c), 32'(count), 32'(presc_exp[c]));
      if (c == 21) chk("presc.ovf_before", 32'(ovf_flag), 0);
      if (c == 22) chk("presc.ovf_at_wrap", 32'(ovf_flag), 1);
    end
    presc_clk = 1'b0;
    stop = 1'b1; flag_clr = 2'b11; step(); stop = 1'b0; flag_clr = '0;
    chk_all("presc.stop", 0, 1'b0, 1'b0, 1'b0);

    // One-shot, period=3, compare=2
    bypass = 1'b1; period = 16'd3; compare = 16'd2; one_shot = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    chk_all("os.start", 0, 1'b0, 1'b0, 1'b1);
    step(); chk_all("os.c1", 1, 1'b0, 1'b0, 1'b1);
    step(); chk_all("os.c2", 2, 1'b1, 1'b0, 1'b1);
    step(); chk_all("os.c3", 3, 1'b1, 1'b0, 1'b1);
    step(); chk_all("os.done", 0, 1'b1, 1'b1, 1'b0);
    step(); step(); chk_all("os.hold", 0, 1'b1, 1'b1, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    chk_all("os.restart", 0, 1'b1, 1'b1, 1'b1);
    step(); chk_all("os.resume", 1, 1'b1, 1'b1, 1'b1);
    stop = 1'b1; step(); stop = 1'b0;

    // Interrupt gating and clear, both flags set
    match_ie = 1'b1; ovf_ie = 1'b0; #1;
    chk("irq.match_only", 32'(irq), 1);
    flag_clr = 2'b01; step(); flag_clr = '0;
    chk("irq.after_clr", 32'(irq), 0);
    chk("irq.ovf_kept", 32'(ovf_flag), 1);
    ovf_ie = 1'b1; #1;
    chk("irq.ovf_en", 32'(irq), 1);
    ovf_ie = 1'b0; flag_clr = 2'b10; step(); flag_clr = '0;
    chk("irq.ovf_clr", 32'(ovf_flag), 0);

    // Clear coinciding with a new match: set wins
    one_shot = 1'b0; period = 16'd5; compare = 16'd2;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    chk_all("setclr.c2", 2, 1'b1, 1'b0, 1'b1);
    compare = 16'd3; flag_clr = 2'b01; step(); flag_clr = '0;
    chk_all("setclr.win", 3, 1'b1, 1'b0, 1'b1);
    flag_clr = 2'b01; step(); flag_clr = '0;
    chk_all("setclr.clr", 4, 1'b0, 1'b0, 1'b1);
    chk("setclr.irq", 32'(irq), 0);

    // start and stop together at count 7
    period = 16'd20; compare = 16'd30;
    start = 1'b1; step(); start = 1'b0;
    repeat (7) step();
    chk_all("ss.c7", 7, 1'b0, 1'b0, 1'b1);
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk_all("ss.both", 0, 1'b0, 1'b0, 1'b1);
    step(); chk_all("ss.c1", 1, 1'b0, 1'b0, 1'b1);
    stop = 1'b1; step(); stop = 1'b0;
    chk_all("ss.stop", 1, 1'b0, 1'b0, 1'b0);
    step(); step(); step();
    chk_all("ss.hold", 1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-count with flags set
    period = 16'd2; compare = 16'd30; ovf_ie = 1'b1; match_ie = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    chk_all("ar.wrap", 0, 1'b0, 1'b1, 1'b1);
    period = 16'd20; compare = 16'd5;
    repeat (9) step();
    chk_all("ar.c9", 9, 1'b1, 1'b1, 1'b1);
    #2 rst = 1'b0; #1;
    chk_all("ar.async", 0, 1'b0, 1'b0, 1'b0);
    chk("ar.irq", 32'(irq), 0);
    step();
    rst = 1'b1;
    step(); step(); step();
    chk_all("ar.no_start", 0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
